lc3_pipe_controller: RTL
========================

// Module: lc3_pipe_controller
// PURPOSE
//  Central sequencer for the 5-stage LC3 pipeline (fetch/decode/execute/memory/writeback).
//  - Generates per-stage enables and ALU/memory bypass selects for the execute stage.
//  - Drives the memory-access FSM (mem_state) and resolves BR/JMP control hazards (br_taken).
//  - Pure control: no datapath storage beyond its own state, counters and flags.
// PARAMETERS
//  BR_BUBBLES  3   cycles PC/fetch held after a control instruction is fetched (legal 2..4)
//  CNT_W       16  width of performance counters (used only with LC3_CTRL_PERF_EN)
// PORTS
//  clk               in   1   clock, all state on rising edge
//  rst               in   1   synchronous reset, active-high
//  complete_instr    in   1   instruction memory returned IMem_dout this cycle
//  complete_data     in   1   data memory access finished this cycle
//  IMem_dout         in   16  instruction being fetched
//  IR                in   16  instruction in decode (entering execute)
//  IR_Exec           in   16  instruction registered by execute
//  NZP               in   3   branch condition from execute (000 when not BR)
//  psr               in   3   current N/Z/P flags from writeback
//  enable_updatePC   out  1   PC register load enable
//  enable_fetch      out  1   fetch stage enable
//  enable_decode     out  1   decode stage enable
//  enable_execute    out  1   execute stage enable
//  enable_writeback  out  1   writeback stage enable
//  bypass_alu_1/_2   out  1   execute src1/src2 take previous aluout
//  bypass_mem_1/_2   out  1   execute src1/src2 take Mem_Bypass_val
//  mem_state         out  2   0=read 1=indirect-read 2=write 3=idle
//  br_taken          out  1   PC loads pcout instead of npc (1-cycle pulse)
// BEHAVIOUR
//  Reset: all enables 0 for the reset cycle, then 1; bypass_* 0; mem_state 3; br_taken 0; FSMs to RUN/IDLE.
//  Opcodes: ALU = ADD 0001/AND 0101/NOT 1001; LOAD = LD 0010/LDR 0110/LDI 1010;
//    STORE = ST 0011/STR 0111/STI 1011; CTRL = BR 0000/JMP 1100.
//  Bypass (combinational):
//    - bypass_alu_1 = IR_Exec in ALU && IR_Exec[11:9]==IR[8:6] && IR reads sr1 (ALU, LDR, STR, JMP).
//    - bypass_alu_2 = IR_Exec in ALU && (IR is ADD/AND with IR[5]=0 && IR[2:0]==IR_Exec[11:9]).
//    - bypass_mem_1/_2: same compare, producer IR_Exec in LOAD; asserted only on the cycle
//      complete_data=1 with mem_state==0.
//    - alu and mem bypass are never asserted together on one operand; alu wins.
//  Memory FSM (mem_state), entered when execute registers a LOAD/STORE:
//    - LD/LDR -> 0; LDI/STI -> 1; ST/STR -> 2.
//    - In 1: on complete_data go to 0 (LDI) or 2 (STI).
//    - In 0 or 2: on complete_data go to 3.
//    - While mem_state!=3: enable_updatePC/fetch/decode/execute=0 (stall).
//    - enable_writeback=1 only in the cycle complete_data ends a read, and for non-memory instrs.
//    - Access latency is unbounded; the controller waits on complete_data.
//  Control FSM: RUN -> HOLD -> RESOLVE -> RUN.
//    - RUN -> HOLD when complete_instr && IMem_dout in CTRL.
//    - HOLD: enable_updatePC=0, enable_fetch=0 for BR_BUBBLES-1 cycles (counter down to 0);
//      decode/execute continue so the branch reaches execute.
//    - RESOLVE (1 cycle): br_taken = |(NZP & psr) || IR_Exec[15:12]==1100; enable_updatePC=1.
//    - Next cycle fetch resumes.
//  Simultaneous events:
//    - A memory stall freezes the HOLD counter.
//    - A CTRL fetch during a memory stall is latched when complete_instr arrives and is
//      acted on after the stall ends.
//  rst mid-access or mid-HOLD: abandons the operation immediately; mem_state 3, br_taken 0.
// CONFIGURATION
//  LC3_CTRL_PERF_EN defined:
//    - adds outputs stall_cnt[CNT_W-1:0] (cycles with enable_fetch=0) and
//      br_cnt[CNT_W-1:0] (br_taken pulses).
//    - both saturate at all-ones and clear on rst.
//  LC3_CTRL_PERF_EN undefined: ports and counters absent; all other behaviour identical.
// TESTING
//  T1 Reset: rst=1 for 2 cycles -> mem_state=3, br_taken=0, bypass_*=0; enables=1 the cycle after rst falls.
//  T2 ALU forward: IR_Exec=ADD R1,R2,R3 (0x1283), IR=ADD R4,R1,#2 (0x1862)
//     -> bypass_alu_1=1, bypass_alu_2=0.
//  T3 LDI: IR_Exec=0xA205
//     -> mem_state 1, complete_data after 3 cycles -> 0, complete_data after 2 more -> 3;
//        fetch stalled throughout; enable_writeback=1 on the final cycle.
//  T4 Branch taken: IMem_dout=0x0E02 (BRnzp) -> enable_fetch=0 for 2 cycles, then
//     br_taken=1 with NZP=111, psr=010.
//  T5 Branch not taken: BRn (0x0802), psr=001 -> br_taken=0 in RESOLVE; fetch resumes next cycle.
//  T6 Reset mid-STI: rst in mem_state=2 -> mem_state=3 next cycle; no enable_writeback pulse;
//     with LC3_CTRL_PERF_EN, stall_cnt=0.

Source files
------------

// File: rtl/lc3_pipe_controller.sv
// Central sequencer for the 5-stage LC3 pipeline: stage enables, execute bypass selects,
// memory-access FSM and BR/JMP hazard handling. Optional perf counters: LC3_CTRL_PERF_EN.
module lc3_pipe_controller #(
   parameter int BR_BUBBLES = 3,
   parameter int CNT_W      = 16
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        complete_instr,
   input  logic        complete_data,
   input  logic [15:0] IMem_dout,
   input  logic [15:0] IR,
   input  logic [15:0] IR_Exec,
   input  logic [2:0]  NZP,
   input  logic [2:0]  psr,
   output logic        enable_updatePC,
   output logic        enable_fetch,
   output logic        enable_decode,
   output logic        enable_execute,
   output logic        enable_writeback,
   output logic        bypass_alu_1,
   output logic        bypass_alu_2,
   output logic        bypass_mem_1,
   output logic        bypass_mem_2,
   output logic [1:0]  mem_state,
   output logic        br_taken
`ifdef LC3_CTRL_PERF_EN
  ,output logic [CNT_W-1:0] stall_cnt,
   output logic [CNT_W-1:0] br_cnt
`endif
);

   if (BR_BUBBLES < 2 || BR_BUBBLES > 4 || CNT_W < 1) begin : g_param_check
      $error("lc3_pipe_controller: BR_BUBBLES must be 2..4 and CNT_W >= 1");
   end

   typedef enum logic [1:0] {MEM_READ = 2'd0, MEM_IND = 2'd1, MEM_WRITE = 2'd2, MEM_IDLE = 2'd3} mem_state_t;
   typedef enum logic [1:0] {CTRL_RUN = 2'd0, CTRL_HOLD = 2'd1, CTRL_RESOLVE = 2'd2} ctrl_state_t;

   localparam int                HOLD_W    = (BR_BUBBLES > 2) ? $clog2(BR_BUBBLES) : 1;
   localparam logic [HOLD_W-1:0] HOLD_LOAD = HOLD_W'(BR_BUBBLES - 2);

   mem_state_t        mem_state_q, mem_state_d;
   ctrl_state_t       ctrl_state_q, ctrl_state_d;
   logic [HOLD_W-1:0] hold_cnt_q, hold_cnt_d;
   logic              ctrl_pend_q, ctrl_pend_d;
   logic              sti_q, sti_d;
   logic              exec_valid_q, exec_valid_d;

   logic [3:0] op_if, op_id, op_ex;
   logic       ex_alu, ex_load, ex_mem, if_ctrl, id_reads_sr1, id_reads_sr2;
   logic       mem_busy, mem_start, ctrl_seen, run_ok, sr1_hit, sr2_hit, mem_fwd;
   logic       unused_bits;

   assign op_if = IMem_dout[15:12];
   assign op_id = IR[15:12];
   assign op_ex = IR_Exec[15:12];

   assign ex_alu       = op_ex inside {4'b0001, 4'b0101, 4'b1001};
   assign ex_load      = op_ex inside {4'b0010, 4'b0110, 4'b1010};
   assign ex_mem       = ex_load || (op_ex inside {4'b0011, 4'b0111, 4'b1011});
   assign if_ctrl      = op_if inside {4'b0000, 4'b1100};
   assign id_reads_sr1 = op_id inside {4'b0001, 4'b0101, 4'b1001, 4'b0110, 4'b0111, 4'b1100};
   assign id_reads_sr2 = (op_id inside {4'b0001, 4'b0101}) && !IR[5];

   // Instruction fields that no decision in this block depends on.
   assign unused_bits = ^{IR[11:9], IR[4:3], IR_Exec[8:0], IMem_dout[11:0]};

   // A LOAD/STORE is acted on once: exec_valid_q drops only for the stale IR_Exec after reset.
   assign mem_busy  = (mem_state_q != MEM_IDLE);
   assign mem_start = !mem_busy && exec_valid_q && ex_mem;
   assign ctrl_seen = complete_instr && if_ctrl;
   assign run_ok    = !rst && !mem_busy;

   assign enable_decode    = run_ok;
   assign enable_execute   = run_ok;
   assign enable_fetch     = run_ok && (ctrl_state_q == CTRL_RUN);
   assign enable_updatePC  = run_ok && (ctrl_state_q != CTRL_HOLD);
   assign enable_writeback = !rst && (((mem_state_q == MEM_READ) && complete_data) ||
                                      (!mem_busy && !mem_start));
   assign br_taken         = run_ok && (ctrl_state_q == CTRL_RESOLVE) &&
                             ((|(NZP & psr)) || (op_ex == 4'b1100));
   assign mem_state        = mem_state_q;

   assign sr1_hit      = id_reads_sr1 && (IR_Exec[11:9] == IR[8:6]);
   assign sr2_hit      = id_reads_sr2 && (IR_Exec[11:9] == IR[2:0]);
   assign mem_fwd      = !rst && (mem_state_q == MEM_READ) && complete_data && ex_load;
   assign bypass_alu_1 = !rst && ex_alu && sr1_hit;
   assign bypass_alu_2 = !rst && ex_alu && sr2_hit;
   assign bypass_mem_1 = mem_fwd && sr1_hit && !bypass_alu_1;
   assign bypass_mem_2 = mem_fwd && sr2_hit && !bypass_alu_2;

   always_comb begin
      mem_state_d  = mem_state_q;
      sti_d        = sti_q;
      ctrl_state_d = ctrl_state_q;
      hold_cnt_d   = hold_cnt_q;
      ctrl_pend_d  = ctrl_pend_q;
      exec_valid_d = exec_valid_q | enable_execute;

      case (mem_state_q)
         MEM_IDLE: begin
            if (mem_start) begin
               sti_d = (op_ex == 4'b1011);
               if (op_ex inside {4'b1010, 4'b1011}) mem_state_d = MEM_IND;
               else if (ex_load)                    mem_state_d = MEM_READ;
               else                                 mem_state_d = MEM_WRITE;
            end
         end
         MEM_IND: if (complete_data) mem_state_d = sti_q ? MEM_WRITE : MEM_READ;
         default: if (complete_data) mem_state_d = MEM_IDLE;
      endcase

      // A memory stall freezes the branch sequence; a CTRL fetched meanwhile waits in ctrl_pend.
      case (ctrl_state_q)
         CTRL_RUN: begin
            if (mem_busy) begin
               ctrl_pend_d = ctrl_pend_q | ctrl_seen;
            end else if (ctrl_pend_q || ctrl_seen) begin
               ctrl_state_d = CTRL_HOLD;
               hold_cnt_d   = HOLD_LOAD;
               ctrl_pend_d  = 1'b0;
            end
         end
         CTRL_HOLD: begin
            if (!mem_busy) begin
               if (hold_cnt_q == '0) ctrl_state_d = CTRL_RESOLVE;
               else                  hold_cnt_d   = hold_cnt_q - HOLD_W'(1);
            end
         end
         CTRL_RESOLVE: if (!mem_busy) ctrl_state_d = CTRL_RUN;
         default:      ctrl_state_d = CTRL_RUN;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         mem_state_q  <= MEM_IDLE;
         sti_q        <= 1'b0;
         ctrl_state_q <= CTRL_RUN;
         hold_cnt_q   <= '0;
         ctrl_pend_q  <= 1'b0;
         exec_valid_q <= 1'b0;
      end else begin
         mem_state_q  <= mem_state_d;
         sti_q        <= sti_d;
         ctrl_state_q <= ctrl_state_d;
         hold_cnt_q   <= hold_cnt_d;
         ctrl_pend_q  <= ctrl_pend_d;
         exec_valid_q <= exec_valid_d;
      end
   end

`ifdef LC3_CTRL_PERF_EN
   logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d, br_cnt_q, br_cnt_d;

   always_comb begin
      stall_cnt_d = stall_cnt_q;
      br_cnt_d    = br_cnt_q;
      if (!enable_fetch && !(&stall_cnt_q)) stall_cnt_d = stall_cnt_q + CNT_W'(1);
      if (br_taken && !(&br_cnt_q))         br_cnt_d    = br_cnt_q + CNT_W'(1);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         stall_cnt_q <= '0;
         br_cnt_q    <= '0;
      end else begin
         stall_cnt_q <= stall_cnt_d;
         br_cnt_q    <= br_cnt_d;
      end
   end

   assign stall_cnt = stall_cnt_q;
   assign br_cnt    = br_cnt_q;
`endif

endmodule
